// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared types and default timing for intersection_phase_arbiter.
//   light_e     : 2-bit per-approach light code (RED=0, YELLOW=1, GREEN=2; 3 unused)
//   arb_state_e : arbiter phase (idle, green, yellow, all-red clearance)
//   Def*        : default parameter values for the arbiter
// -----------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [1:0] {
        LightRed    = 2'd0,
        LightYellow = 2'd1,
        LightGreen  = 2'd2
    } light_e;

    typedef enum logic [1:0] {
        StIdle,
        StGreen,
        StYellow,
        StAllred
    } arb_state_e;

    localparam int unsigned DefNAppr    = 4;
    localparam int unsigned DefMinGreen = 4;
    localparam int unsigned DefMaxGreen = 12;
    localparam int unsigned DefYellowT  = 2;
    localparam int unsigned DefAllredT  = 3;

endpackage

// File: rtl/phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// Single up-counter shared by all arbiter phases. A load restarts the count at
// load_val_i; otherwise the count advances while en_i is high and saturates at
// SatVal instead of wrapping. at_term_o flags count >= term_i.
//   clk_i      : clock, rising edge
//   rst_ni     : asynchronous active-low reset (count -> 0)
//   load_i     : load load_val_i this cycle (wins over en_i)
//   load_val_i : value loaded on load_i
//   en_i       : advance the count by one (saturating)
//   term_i     : terminal value for the compare
//   count_o    : current count
//   at_term_o  : count_o >= term_i
// -----------------------------------------------------------------------------
module phase_timer #(
    parameter int unsigned Width  = 4,
    parameter int unsigned SatVal = 12
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    input  logic [Width-1:0] term_i,
    output logic [Width-1:0] count_o,
    output logic             at_term_o
);

    logic [Width-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q < Width'(SatVal))) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign at_term_o = (count_q >= term_i);

endmodule

// File: rtl/intersection_phase_arbiter.sv
// -----------------------------------------------------------------------------
// intersection_phase_arbiter
// Shares one right-of-way among N_APPR approaches with round-robin arbitration
// and min-green / max-green / yellow / all-red timing.
//   clk       : clock, rising edge
//   clear_n   : asynchronous active-low reset
//   req       : level vehicle request per approach
//   light     : 2-bit light code per approach, bits [2i+1:2i] = approach i
//   grant     : one-hot approach currently GREEN or YELLOW, 0 otherwise
//   busy      : high in every phase except idle
// Optional (macro EMERG_PREEMPT_EN):
//   emerg_req : emergency pre-emption request
//   emerg_idx : approach the emergency vehicle needs
// All outputs are registered from the current phase, so a request sampled at
// edge k shows GREEN after edge k+1.
// -----------------------------------------------------------------------------
module intersection_phase_arbiter
    import traffic_pkg::*;
#(
    parameter int unsigned N_APPR    = DefNAppr,
    parameter int unsigned MIN_GREEN = DefMinGreen,
    parameter int unsigned MAX_GREEN = DefMaxGreen,
    parameter int unsigned YELLOW_T  = DefYellowT,
    parameter int unsigned ALLRED_T  = DefAllredT,
    localparam int unsigned IdxW     = $clog2(N_APPR),
    localparam int unsigned TimerW   = $clog2(MAX_GREEN + 1)
) (
    input  logic                  clk,
    input  logic                  clear_n,
    input  logic [N_APPR-1:0]     req,
`ifdef EMERG_PREEMPT_EN
    input  logic                  emerg_req,
    input  logic [IdxW-1:0]       emerg_idx,
`endif
    output logic [2*N_APPR-1:0]   light,
    output logic [N_APPR-1:0]     grant,
    output logic                  busy
);

    arb_state_e state_d, state_q;
    logic [IdxW-1:0] g_d, g_q;
    logic [IdxW-1:0] rr_ptr_d, rr_ptr_q;
    logic [2*N_APPR-1:0] light_d, light_q;
    logic [N_APPR-1:0] grant_d, grant_q;
    logic busy_d, busy_q;

    logic              tmr_load, tmr_en, tmr_at_term;
    logic [TimerW-1:0] tmr_term, tmr_cnt;

    logic [N_APPR-1:0] own_mask;
    logic              own_req, other_req, green_exit;
    logic [IdxW:0]     pick;

    // First requesting approach scanning upward from ptr (mod N_APPR).
    // Returns {found, index}.
    function automatic logic [IdxW:0] rr_pick(input logic [N_APPR-1:0] r,
                                              input logic [IdxW-1:0] ptr);
        logic        found;
        logic [IdxW-1:0] win;
        int unsigned idx;
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 0; k < N_APPR; k++) begin
            idx = (32'(ptr) + k) % N_APPR;
            if (!found && r[IdxW'(idx)]) begin
                found = 1'b1;
                win   = IdxW'(idx);
            end
        end
        return {found, win};
    endfunction

    phase_timer #(
        .Width  (TimerW),
        .SatVal (MAX_GREEN)
    ) u_timer (
        .clk_i      (clk),
        .rst_ni     (clear_n),
        .load_i     (tmr_load),
        .load_val_i (TimerW'(1)),
        .en_i       (tmr_en),
        .term_i     (tmr_term),
        .count_o    (tmr_cnt),
        .at_term_o  (tmr_at_term)
    );

    // Timer holds the 1-based cycle number within the current phase, so the
    // terminal compare is simply the phase length.
    always_comb begin
        tmr_term = '0;
        unique case (state_q)
            StGreen:  tmr_term = TimerW'(MIN_GREEN);
            StYellow: tmr_term = TimerW'(YELLOW_T);
            StAllred: tmr_term = TimerW'(ALLRED_T);
            default:  tmr_term = '0;
        endcase
    end

    always_comb begin
        own_mask       = '0;
        own_mask[g_q]  = 1'b1;
        own_req        = req[g_q];
        other_req      = |(req & ~own_mask);

        pick = rr_pick(req, rr_ptr_q);
`ifdef EMERG_PREEMPT_EN
        if (emerg_req) begin
            pick = {1'b1, emerg_idx};
        end
`endif

        // Max-green clause is implied by the min-green one, kept for clarity.
        green_exit = (tmr_at_term && (other_req || !own_req)) ||
                     ((tmr_cnt == TimerW'(MAX_GREEN)) && other_req);
`ifdef EMERG_PREEMPT_EN
        // Emergency overrides both green limits: leave at once or hold forever.
        if (emerg_req) begin
            green_exit = (emerg_idx != g_q);
        end
`endif

        state_d  = state_q;
        g_d      = g_q;
        rr_ptr_d = rr_ptr_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick[IdxW]) begin
                    state_d  = StGreen;
                    g_d      = pick[IdxW-1:0];
                    tmr_load = 1'b1;
                end
            end
            StGreen: begin
                tmr_en = 1'b1;
                if (green_exit) begin
                    state_d  = StYellow;
                    tmr_load = 1'b1;
                end
            end
            StYellow: begin
                tmr_en = 1'b1;
                if (tmr_at_term) begin
                    state_d  = StAllred;
                    tmr_load = 1'b1;
                    // Served approach drops to lowest priority for the next pick.
                    rr_ptr_d = IdxW'((32'(g_q) + 32'd1) % N_APPR);
                end
            end
            StAllred: begin
                tmr_en = 1'b1;
                if (tmr_at_term) begin
                    tmr_load = 1'b1;
                    if (pick[IdxW]) begin
                        state_d = StGreen;
                        g_d     = pick[IdxW-1:0];
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode from the registered phase; registered once more below.
    always_comb begin
        light_d = '0;
        grant_d = '0;
        busy_d  = (state_q != StIdle);
        unique case (state_q)
            StGreen: begin
                light_d[{g_q, 1'b0} +: 2] = LightGreen;
                grant_d[g_q]              = 1'b1;
            end
            StYellow: begin
                light_d[{g_q, 1'b0} +: 2] = LightYellow;
                grant_d[g_q]              = 1'b1;
            end
            default: begin
                light_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q  <= StIdle;
            g_q      <= '0;
            rr_ptr_q <= '0;
            light_q  <= '0;
            grant_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            rr_ptr_q <= rr_ptr_d;
            light_q  <= light_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
        end
    end

    assign light = light_q;
    assign grant = grant_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_intersection_phase_arbiter.sv
// -----------------------------------------------------------------------------
// tb_intersection_phase_arbiter
// Directed self-checking bench for intersection_phase_arbiter (N_APPR=4,
// MIN_GREEN=4, MAX_GREEN=12, YELLOW_T=2, ALLRED_T=3). Edge numbering: edge 1
// is the first rising edge after clear_n is released. Build with
// EMERG_PREEMPT_EN defined to include the pre-emption scenario.
// -----------------------------------------------------------------------------
module tb_intersection_phase_arbiter;

    logic       clk     = 1'b0;
    logic       clear_n = 1'b0;
    logic [3:0] req     = '0;
`ifdef EMERG_PREEMPT_EN
    logic       emerg_req = 1'b0;
    logic [1:0] emerg_idx = '0;
`endif
    logic [7:0] light;
    logic [3:0] grant;
    logic       busy;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    intersection_phase_arbiter #(
        .N_APPR    (4),
        .MIN_GREEN (4),
        .MAX_GREEN (12),
        .YELLOW_T  (2),
        .ALLRED_T  (3)
    ) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .req       (req),
`ifdef EMERG_PREEMPT_EN
        .emerg_req (emerg_req),
        .emerg_idx (emerg_idx),
`endif
        .light     (light),
        .grant     (grant),
        .busy      (busy)
    );

    // Every cycle: at most one non-RED approach, no code 3, grant == non-RED set.
    always @(negedge clk) begin
        int         nonred;
        logic [3:0] exp_grant;
        logic       bad_code;
        nonred    = 0;
        exp_grant = '0;
        bad_code  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (light[2*i +: 2] != 2'd0) begin
                nonred++;
                exp_grant[i] = 1'b1;
            end
            if (light[2*i +: 2] == 2'd3) bad_code = 1'b1;
        end
        n_total++;
        if (nonred > 1 || bad_code || grant !== exp_grant)
            $display("FAIL invariant t=%0t: light=%h grant=%b, required <=1 non-RED, no code 3, grant=%b",
                     $time, light, grant, exp_grant);
        else
            n_pass++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req     = '0;
        clear_n = 1'b0;
        @(posedge clk);
        #1;
        n_total++;
        if (light !== 8'h00 || grant !== 4'h0 || busy !== 1'b0)
            $display("FAIL reset_outputs: light=%h grant=%b busy=%b, required 00 0000 0",
                     light, grant, busy);
        else
            n_pass++;
        @(negedge clk);
        clear_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_total++;
        if (dut.tmr_cnt !== 4'd0 || dut.rr_ptr_q !== 2'd0)
            $display("FAIL reset_internal: timer=%0d rr_ptr=%0d, required 0 0",
                     dut.tmr_cnt, dut.rr_ptr_q);
        else
            n_pass++;
    endtask

    task automatic test_hold_green();
        logic ok;
        apply_reset();
        req = 4'b0100;
        tick();  // edge 1
        n_total++;
        if (light !== 8'h00 || busy !== 1'b0)
            $display("FAIL hold_latency: light=%h busy=%b, required 00 0", light, busy);
        else
            n_pass++;
        tick();  // edge 2
        n_total++;
        if (light !== 8'h20 || grant !== 4'b0100 || busy !== 1'b1)
            $display("FAIL hold_first_green: light=%h grant=%b busy=%b, required 20 0100 1",
                     light, grant, busy);
        else
            n_pass++;
        ok = 1'b1;
        repeat (30) begin
            tick();
            if (light !== 8'h20 || grant !== 4'b0100) ok = 1'b0;
        end
        n_total++;
        if (!ok)
            $display("FAIL hold_30_cycles: light=%h grant=%b, required 20 0100 throughout",
                     light, grant);
        else
            n_pass++;
        n_total++;
        if (dut.tmr_cnt !== 4'd12)
            $display("FAIL hold_timer_sat: timer=%0d, required 12", dut.tmr_cnt);
        else
            n_pass++;
    endtask

    task automatic test_handoff();
        logic [7:0] exp_l [11];
        exp_l = '{8'h00, 8'h20, 8'h20, 8'h20, 8'h20, 8'h10, 8'h10,
                  8'h00, 8'h00, 8'h00, 8'h02};
        apply_reset();
        req = 4'b0100;
        for (int e = 1; e <= 11; e++) begin
            tick();
            n_total++;
            if (light !== exp_l[e-1])
                $display("FAIL handoff edge %0d: light=%h, required %h", e, light, exp_l[e-1]);
            else
                n_pass++;
            if (e == 2) req = 4'b0101;
        end
        n_total++;
        if (grant !== 4'b0001 || dut.rr_ptr_q !== 2'd3)
            $display("FAIL handoff_final: grant=%b rr_ptr=%0d, required 0001 3",
                     grant, dut.rr_ptr_q);
        else
            n_pass++;
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_l;
        int         ph, ap;
        apply_reset();
        req = 4'b1111;
        for (int e = 1; e <= 44; e++) begin
            tick();
            exp_l = 8'h00;
            // 9-edge period: 4 GREEN, 2 YELLOW, 3 all-RED, approaches 0,1,2,3,0
            if (e >= 2) begin
                ph = (e - 2) % 9;
                ap = ((e - 2) / 9) % 4;
                if (ph < 4)      exp_l = 8'd2 << (2 * ap);
                else if (ph < 6) exp_l = 8'd1 << (2 * ap);
            end
            n_total++;
            if (light !== exp_l)
                $display("FAIL round_robin edge %0d: light=%h, required %h", e, light, exp_l);
            else
                n_pass++;
        end
    endtask

    task automatic test_pulse();
        logic [7:0] exp_l [11];
        logic       exp_b [11];
        exp_l = '{8'h00, 8'h08, 8'h08, 8'h08, 8'h08, 8'h04, 8'h04,
                  8'h00, 8'h00, 8'h00, 8'h00};
        exp_b = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                  1'b1, 1'b1, 1'b1, 1'b0};
        apply_reset();
        req = 4'b0010;
        for (int e = 1; e <= 11; e++) begin
            tick();
            if (e == 1) req = 4'b0000;
            n_total++;
            if (light !== exp_l[e-1] || busy !== exp_b[e-1])
                $display("FAIL pulse edge %0d: light=%h busy=%b, required %h %b",
                         e, light, busy, exp_l[e-1], exp_b[e-1]);
            else
                n_pass++;
        end
    endtask

    task automatic test_reset_mid_yellow();
        apply_reset();
        req = 4'b1111;
        repeat (15) tick();  // edge 15: approach 1 in YELLOW
        n_total++;
        if (light !== 8'h04 || dut.rr_ptr_q !== 2'd1)
            $display("FAIL midyellow_pre: light=%h rr_ptr=%0d, required 04 1",
                     light, dut.rr_ptr_q);
        else
            n_pass++;
        #2;
        clear_n = 1'b0;
        #1;
        n_total++;
        if (light !== 8'h00 || grant !== 4'h0 || busy !== 1'b0)
            $display("FAIL midyellow_async: light=%h grant=%b busy=%b, required 00 0000 0",
                     light, grant, busy);
        else
            n_pass++;
        @(negedge clk);
        clear_n = 1'b1;
        tick();  // edge 1
        tick();  // edge 2
        n_total++;
        if (light !== 8'h02 || grant !== 4'b0001)
            $display("FAIL midyellow_rearb: light=%h grant=%b, required 02 0001", light, grant);
        else
            n_pass++;
    endtask

`ifdef EMERG_PREEMPT_EN
    task automatic test_emergency();
        logic [7:0] exp_l [9];
        exp_l = '{8'h00, 8'h02, 8'h02, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h80};
        apply_reset();
        req = 4'b0011;
        for (int e = 1; e <= 9; e++) begin
            tick();
            n_total++;
            if (light !== exp_l[e-1])
                $display("FAIL emergency edge %0d: light=%h, required %h", e, light, exp_l[e-1]);
            else
                n_pass++;
            if (e == 2) begin
                emerg_req = 1'b1;
                emerg_idx = 2'd3;
            end
        end
        emerg_req = 1'b0;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_hold_green();
        test_handoff();
        test_round_robin();
        test_pulse();
        test_reset_mid_yellow();
`ifdef EMERG_PREEMPT_EN
        test_emergency();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
